dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 8: number of low address bits forwarded; upper Address bits SHALL be driven 0.
REQ-002 clk  input  1  system clock; the block SHALL use this single clock only.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 cpu_req_valid / cpu_req_we  input  1 each  CPU request valid / write (store) flag.
REQ-005 cpu_req_ctrl  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-006 cpu_req_addr / cpu_req_wdata  input  32 each  byte address / store data.
REQ-007 cpu_req_ready  output  1  CPU request accepted this cycle when valid&ready.
REQ-008 cpu_rsp_valid / cpu_rsp_err  output  1 each  response strobe / access-error flag.
REQ-009 cpu_rsp_rdata  output  32  load data.
REQ-010 dbg_*  same widths and directions as REQ-004..REQ-009  second requester (debug/loader port).
REQ-011 DMWr  output  1  memory write enable.
REQ-012 DMCtrl  output  3  memory size control.
REQ-013 Address / DataWr  output  32 each  memory address / write data.
REQ-014 DataRd  input  32  combinational memory read data.

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS and RESP, with transitions IDLE->ACCESS on accept, ACCESS->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-016 In IDLE, ready SHALL be asserted only to the arbitration winner among valid requesters; no ready in ACCESS/RESP.
REQ-017 Arbitration SHALL be round-robin: with both valid, grant the port not granted last; a single valid port always wins.
REQ-018 On accept, we/ctrl/addr/wdata and the port id SHALL be latched; later requester input changes are ignored.
REQ-019 Error check at accept: H/HU with addr[0]=1, W with addr[1:0]!=0, ctrl in {011,110,111}, or we with ctrl in {100,101} SHALL set err.
REQ-020 In ACCESS, DMCtrl/Address/DataWr SHALL carry the latched request, and DMWr = latched we & ~err & ~rst.
REQ-021 In ACCESS, DataRd SHALL be registered into rdata; rdata SHALL be 0 for writes and errored accesses.
REQ-022 In RESP, rsp_valid SHALL be high for exactly one cycle on the granted port only, with rdata and err valid that cycle.
REQ-023 Latency SHALL be 2 cycles from the accept edge to rsp_valid; throughput SHALL be one access per 3 cycles.
REQ-024 Outside ACCESS, the memory outputs SHALL be DMWr=0, DMCtrl=010, Address=0, DataWr=0.
REQ-025 The non-granted port's rsp_valid SHALL stay 0; rsp_rdata/rsp_err SHALL hold their last values when rsp_valid=0.

Reset
REQ-026 rst SHALL force state IDLE, last-grant pointer to dbg (so CPU wins the first tie), all rsp_valid 0, and rsp_rdata/err 0.
REQ-027 rst asserted in ACCESS or RESP SHALL abort the access with no memory write and no response.

Structure
REQ-028 Package dmem_pkg SHALL hold the DMCtrl encodings, the FSM state enum and a request struct (we, ctrl, addr, wdata).
REQ-029 Sub-module rr_arb2 (2-way round-robin, grant pointer inside) SHALL implement the arbitration.

Verification
REQ-030 Single CPU SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> DMWr pulsed once, read rsp_rdata=0xDEADBEEF at accept+2.
REQ-031 CPU and dbg valid together for 4 requests each -> grants alternate CPU,dbg,CPU,..., starting with CPU after reset.
REQ-032 CPU LH addr 0x21 -> rsp_err=1, rsp_rdata=0, DMWr never asserted.
REQ-033 dbg SB addr 0x05 data 0x80, then CPU LB 0x05 / LBU 0x05 -> 0xFFFFFF80 / 0x00000080.
REQ-034 rst asserted during ACCESS of an SW -> no DMWr, no rsp_valid; a subsequent LW returns the prior contents.
REQ-035 Requester changes addr/wdata after accept -> memory sees the latched values.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: size encodings, FSM states,
// the latched request record and the access-legality check.
package dmem_pkg;

   localparam logic [2:0] CTRL_B  = 3'b000;
   localparam logic [2:0] CTRL_H  = 3'b001;
   localparam logic [2:0] CTRL_W  = 3'b010;
   localparam logic [2:0] CTRL_BU = 3'b100;
   localparam logic [2:0] CTRL_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } state_t;

   typedef struct packed {
      logic        we;
      logic [2:0]  ctrl;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   // Misaligned halves/words, unknown size codes and unsigned stores are illegal.
   function automatic logic access_err(input req_t r);
      logic err;
      case (r.ctrl)
         CTRL_B:  err = 1'b0;
         CTRL_H:  err = r.addr[0];
         CTRL_W:  err = |r.addr[1:0];
         CTRL_BU: err = r.we;
         CTRL_HU: err = r.we | r.addr[0];
         default: err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; index 0 is the CPU, index 1 the debug port.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic last_dbg;

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_dbg ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // Pointer starts at debug so the CPU wins the first tie after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_dbg <= 1'b1;
      end else if (advance) begin
         last_dbg <= grant[1];
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one combinational data memory between the CPU and a debug/loader
// port; each access runs IDLE -> ACCESS -> RESP.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_BITS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req_valid,
   input  logic        cpu_req_we,
   input  logic [2:0]  cpu_req_ctrl,
   input  logic [31:0] cpu_req_addr,
   input  logic [31:0] cpu_req_wdata,
   output logic        cpu_req_ready,
   output logic        cpu_rsp_valid,
   output logic        cpu_rsp_err,
   output logic [31:0] cpu_rsp_rdata,
   input  logic        dbg_req_valid,
   input  logic        dbg_req_we,
   input  logic [2:0]  dbg_req_ctrl,
   input  logic [31:0] dbg_req_addr,
   input  logic [31:0] dbg_req_wdata,
   output logic        dbg_req_ready,
   output logic        dbg_rsp_valid,
   output logic        dbg_rsp_err,
   output logic [31:0] dbg_rsp_rdata,
   output logic        DMWr,
   output logic [2:0]  DMCtrl,
   output logic [31:0] Address,
   output logic [31:0] DataWr,
   input  logic [31:0] DataRd
);

   localparam logic [31:0] ADDR_MASK = 32'((64'd1 << ADDR_BITS) - 64'd1);

   state_t     state;
   state_t     next_state;
   req_t       req_q;
   req_t       sel_req;
   logic       port_q;
   logic       err_q;
   logic       accept;
   logic [1:0] grant;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     ({dbg_req_valid, cpu_req_valid}),
      .advance (accept),
      .grant   (grant)
   );

   always_comb begin
      accept  = (state == ST_IDLE) && (|grant);
      sel_req = grant[1] ? '{dbg_req_we, dbg_req_ctrl, dbg_req_addr, dbg_req_wdata}
                         : '{cpu_req_we, cpu_req_ctrl, cpu_req_addr, cpu_req_wdata};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:   next_state = accept ? ST_ACCESS : ST_IDLE;
         ST_ACCESS: next_state = ST_RESP;
         ST_RESP:   next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   // Memory bus idles at word size with everything else zero.
   always_comb begin
      cpu_req_ready = (state == ST_IDLE) && grant[0];
      dbg_req_ready = (state == ST_IDLE) && grant[1];
      cpu_rsp_valid = (state == ST_RESP) && !port_q && !rst;
      dbg_rsp_valid = (state == ST_RESP) && port_q && !rst;
      DMWr          = 1'b0;
      DMCtrl        = CTRL_W;
      Address       = '0;
      DataWr        = '0;
      if (state == ST_ACCESS) begin
         DMWr    = req_q.we & ~err_q & ~rst;
         DMCtrl  = req_q.ctrl;
         Address = req_q.addr & ADDR_MASK;
         DataWr  = req_q.wdata;
      end
   end

   // Response registers are per port so the idle port keeps its last result.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q         <= '0;
         port_q        <= 1'b0;
         err_q         <= 1'b0;
         cpu_rsp_rdata <= '0;
         cpu_rsp_err   <= 1'b0;
         dbg_rsp_rdata <= '0;
         dbg_rsp_err   <= 1'b0;
      end else begin
         if (accept) begin
            req_q  <= sel_req;
            port_q <= grant[1];
            err_q  <= access_err(sel_req);
         end
         if (state == ST_ACCESS) begin
            if (port_q) begin
               dbg_rsp_rdata <= (req_q.we || err_q) ? 32'h0 : DataRd;
               dbg_rsp_err   <= err_q;
            end else begin
               cpu_rsp_rdata <= (req_q.we || err_q) ? 32'h0 : DataRd;
               cpu_rsp_err   <= err_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised scoreboard bench for dmem_arbiter with a byte-array memory
// behind the bus and a transaction-level reference model.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  ctrl;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req_valid, cpu_req_we, cpu_req_ready, cpu_rsp_valid, cpu_rsp_err;
   logic [2:0]  cpu_req_ctrl;
   logic [31:0] cpu_req_addr, cpu_req_wdata, cpu_rsp_rdata;
   logic        dbg_req_valid, dbg_req_we, dbg_req_ready, dbg_rsp_valid, dbg_rsp_err;
   logic [2:0]  dbg_req_ctrl;
   logic [31:0] dbg_req_addr, dbg_req_wdata, dbg_rsp_rdata;
   logic        DMWr;
   logic [2:0]  DMCtrl;
   logic [31:0] Address, DataWr, DataRd;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;
   bit   model_last_dbg = 1'b1;

   logic [7:0] dev_mem [256];
   logic [7:0] ref_mem [256];
   req_t       stim_q [2][$];
   rsp_t       exp_q [2][$];
   int         acc_q [2][$];
   int         order_q [$];
   wr_t        exp_wr [$];
   rsp_t       last_rsp [2];

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_BITS(8)) dut (
      .clk(clk), .rst(rst),
      .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we), .cpu_req_ctrl(cpu_req_ctrl),
      .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata), .cpu_req_ready(cpu_req_ready),
      .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_err(cpu_rsp_err), .cpu_rsp_rdata(cpu_rsp_rdata),
      .dbg_req_valid(dbg_req_valid), .dbg_req_we(dbg_req_we), .dbg_req_ctrl(dbg_req_ctrl),
      .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata), .dbg_req_ready(dbg_req_ready),
      .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_err(dbg_rsp_err), .dbg_rsp_rdata(dbg_rsp_rdata),
      .DMWr(DMWr), .DMCtrl(DMCtrl), .Address(Address), .DataWr(DataWr), .DataRd(DataRd)
   );

   function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] c);
      case (c)
         3'b000:  return {{24{w[7]}}, w[7:0]};
         3'b001:  return {{16{w[15]}}, w[15:0]};
         3'b100:  return {24'h0, w[7:0]};
         3'b101:  return {16'h0, w[15:0]};
         default: return w;
      endcase
   endfunction

   // Little-endian byte memory standing in for the real data RAM.
   always_comb begin
      logic [7:0] a;
      a = Address[7:0];
      DataRd = extend({dev_mem[a + 8'd3], dev_mem[a + 8'd2], dev_mem[a + 8'd1], dev_mem[a]}, DMCtrl);
   end

   always @(posedge clk) begin
      int n;
      n = (DMCtrl[1:0] == 2'b00) ? 1 : (DMCtrl[1:0] == 2'b01) ? 2 : 4;
      if (DMWr) begin
         for (int k = 0; k < n; k++) dev_mem[8'(Address[7:0] + k)] = DataWr[8*k +: 8];
      end
      cyc = cyc + 1;
      if (rst) begin
         last_rsp[0] = '{32'h0, 1'b0};
         last_rsp[1] = '{32'h0, 1'b0};
      end
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h want=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: apply the access rules directly to a byte array.
   task automatic model_exec(input int p, input req_t r);
      int          size;
      bit          sgn, e;
      logic [31:0] v;
      logic [7:0]  a;
      size = (r.ctrl[1:0] == 2'b00) ? 1 : (r.ctrl[1:0] == 2'b01) ? 2 : 4;
      sgn  = !r.ctrl[2];
      a    = r.addr[7:0];
      e    = (r.ctrl inside {3'b011, 3'b110, 3'b111}) || (r.addr % size != 0) || (r.we && !sgn);
      v    = 32'h0;
      if (!e && r.we) begin
         for (int k = 0; k < size; k++) ref_mem[8'(a + k)] = r.wdata[8*k +: 8];
         exp_wr.push_back('{{24'h0, a}, r.wdata, r.ctrl});
      end else if (!e) begin
         for (int k = 0; k < size; k++) v = v + (32'(ref_mem[8'(a + k)]) << (8 * k));
         if (sgn && size < 4 && v[8*size-1]) v = v - (32'd1 << (8 * size));
      end
      exp_q[p].push_back('{v, e});
      order_q.push_back(p);
   endtask

   task automatic model_schedule();
      req_t c[$];
      req_t d[$];
      c = stim_q[0];
      d = stim_q[1];
      while (c.size() > 0 && d.size() > 0) begin
         if (model_last_dbg) model_exec(0, c.pop_front());
         else model_exec(1, d.pop_front());
         model_last_dbg = !model_last_dbg;
      end
      while (c.size() > 0) begin
         model_exec(0, c.pop_front());
         model_last_dbg = 1'b0;
      end
      while (d.size() > 0) begin
         model_exec(1, d.pop_front());
         model_last_dbg = 1'b1;
      end
   endtask

   task automatic drive_port(input int p, input bit v, input req_t r);
      if (p == 0) begin
         cpu_req_valid = v; cpu_req_we = r.we; cpu_req_ctrl = r.ctrl;
         cpu_req_addr = r.addr; cpu_req_wdata = r.wdata;
      end else begin
         dbg_req_valid = v; dbg_req_we = r.we; dbg_req_ctrl = r.ctrl;
         dbg_req_addr = r.addr; dbg_req_wdata = r.wdata;
      end
   endtask

   function automatic req_t rand_req();
      req_t r;
      r.we    = 1'($urandom);
      r.ctrl  = 3'($urandom);
      r.addr  = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 31));
      r.wdata = $urandom;
      return r;
   endfunction

   function automatic req_t mk(input logic we, input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
      req_t r;
      r = '{we, c, a, d};
      return r;
   endfunction

   // Present each port's queued requests back to back; inputs are scrambled after the last accept.
   task automatic apply_stimulus();
      int  t;
      bit  hs [2];
      model_schedule();
      for (int p = 0; p < 2; p++) begin
         if (stim_q[p].size() > 0) drive_port(p, 1'b1, stim_q[p][0]);
      end
      t = 0;
      while ((stim_q[0].size() > 0 || stim_q[1].size() > 0) && t < 300) begin
         @(negedge clk);
         hs[0] = cpu_req_valid && cpu_req_ready;
         hs[1] = dbg_req_valid && dbg_req_ready;
         for (int p = 0; p < 2; p++) if (hs[p]) acc_q[p].push_back(cyc);
         @(posedge clk);
         #1;
         for (int p = 0; p < 2; p++) begin
            if (hs[p]) begin
               void'(stim_q[p].pop_front());
               if (stim_q[p].size() > 0) drive_port(p, 1'b1, stim_q[p][0]);
               else drive_port(p, 1'b0, rand_req());
            end
         end
         t++;
      end
      if (stim_q[0].size() > 0 || stim_q[1].size() > 0) begin
         check_output("accept_timeout", 32'(stim_q[0].size() + stim_q[1].size()), 32'h0);
         stim_q[0].delete();
         stim_q[1].delete();
         drive_port(0, 1'b0, rand_req());
         drive_port(1, 1'b0, rand_req());
      end
      t = 0;
      while ((exp_q[0].size() > 0 || exp_q[1].size() > 0) && t < 20) begin
         @(posedge clk);
         t++;
      end
      if (exp_q[0].size() > 0 || exp_q[1].size() > 0) begin
         check_output("rsp_timeout", 32'(exp_q[0].size() + exp_q[1].size()), 32'h0);
         exp_q[0].delete(); exp_q[1].delete(); acc_q[0].delete(); acc_q[1].delete();
         order_q.delete();
      end
      @(negedge clk);
      check_output("idle_dmctrl", 32'(DMCtrl), 32'(CTRL_W));
      check_output("idle_address", Address, 32'h0);
      check_output("idle_datawr", DataWr, 32'h0);
      @(posedge clk);
      #1;
   endtask

   task automatic monitor_port(input int p, input logic v, input logic [31:0] rd, input logic e);
      rsp_t x;
      if (v) begin
         if (exp_q[p].size() == 0) begin
            check_output($sformatf("rsp_unexpected_p%0d", p), 32'h1, 32'h0);
         end else begin
            x = exp_q[p].pop_front();
            check_output($sformatf("rsp_rdata_p%0d", p), rd, x.rdata);
            check_output($sformatf("rsp_err_p%0d", p), 32'(e), 32'(x.err));
            if (order_q.size() > 0) check_output("grant_order", 32'(p), 32'(order_q.pop_front()));
            if (acc_q[p].size() > 0) check_output("latency", 32'(cyc - acc_q[p].pop_front()), 32'd2);
            last_rsp[p] = x;
         end
      end else begin
         check_output($sformatf("hold_rdata_p%0d", p), rd, last_rsp[p].rdata);
         check_output($sformatf("hold_err_p%0d", p), 32'(e), 32'(last_rsp[p].err));
      end
   endtask

   always @(negedge clk) begin
      wr_t w;
      if (mon_en) begin
         if (cpu_rsp_valid && dbg_rsp_valid) check_output("both_rsp_valid", 32'h1, 32'h0);
         monitor_port(0, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_err);
         monitor_port(1, dbg_rsp_valid, dbg_rsp_rdata, dbg_rsp_err);
         if (DMWr) begin
            if (exp_wr.size() == 0) begin
               check_output("dmwr_unexpected", 32'h1, 32'h0);
            end else begin
               w = exp_wr.pop_front();
               check_output("wr_address", Address, w.addr);
               check_output("wr_data", DataWr, w.data);
               check_output("wr_ctrl", 32'(DMCtrl), 32'(w.ctrl));
            end
         end
      end
   end

   initial begin
      int n;
      for (int i = 0; i < 256; i++) begin
         dev_mem[i] = 8'($urandom);
         ref_mem[i] = dev_mem[i];
      end
      rst = 1'b1;
      drive_port(0, 1'b0, mk(0, CTRL_W, 0, 0));
      drive_port(1, 1'b0, mk(0, CTRL_W, 0, 0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_output("rst_cpu_rsp_valid", 32'(cpu_rsp_valid), 32'h0);
      check_output("rst_dbg_rsp_valid", 32'(dbg_rsp_valid), 32'h0);
      check_output("rst_cpu_rdata", cpu_rsp_rdata, 32'h0);
      check_output("rst_dbg_rdata", dbg_rsp_rdata, 32'h0);
      check_output("rst_cpu_err", 32'(cpu_rsp_err), 32'h0);
      check_output("rst_dbg_err", 32'(dbg_rsp_err), 32'h0);
      check_output("rst_dmwr", 32'(DMWr), 32'h0);
      check_output("rst_dmctrl", 32'(DMCtrl), 32'(CTRL_W));
      check_output("rst_address", Address, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_last_dbg = 1'b1;
      mon_en = 1'b1;

      stim_q[0].push_back(mk(1, CTRL_W, 32'h10, 32'hDEADBEEF));
      stim_q[0].push_back(mk(0, CTRL_W, 32'h10, 32'h0));
      apply_stimulus();

      for (int i = 0; i < 4; i++) begin
         stim_q[0].push_back(mk(0, CTRL_W, 32'(4 * i), 32'h0));
         stim_q[1].push_back(mk(0, CTRL_W, 32'(4 * i + 16), 32'h0));
      end
      apply_stimulus();

      stim_q[0].push_back(mk(0, CTRL_H, 32'h21, 32'h0));
      apply_stimulus();

      stim_q[1].push_back(mk(1, CTRL_B, 32'h05, 32'h80));
      stim_q[0].push_back(mk(0, CTRL_B, 32'h05, 32'h0));
      stim_q[0].push_back(mk(0, CTRL_BU, 32'h05, 32'h0));
      apply_stimulus();

      // CPU alone moves the pointer, so the next tie must go to debug.
      stim_q[0].push_back(mk(1, CTRL_W, 32'hABCD_0030, 32'h12345678));
      apply_stimulus();
      stim_q[0].push_back(mk(0, CTRL_W, 32'h30, 32'h0));
      stim_q[1].push_back(mk(0, CTRL_HU, 32'h32, 32'h0));
      apply_stimulus();

      stim_q[0].push_back(mk(1, CTRL_W, 32'h40, 32'hCAFEF00D));
      apply_stimulus();
      drive_port(0, 1'b1, mk(1, CTRL_W, 32'h40, 32'h0BADC0DE));
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cpu_req_ready && n < 20);
      check_output("abort_ready", 32'(cpu_req_ready), 32'h1);
      @(posedge clk);
      #1;
      drive_port(0, 1'b0, mk(0, CTRL_W, 0, 0));
      rst = 1'b1;
      @(negedge clk);
      check_output("abort_dmwr", 32'(DMWr), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_last_dbg = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      stim_q[0].push_back(mk(0, CTRL_W, 32'h40, 32'h0));
      apply_stimulus();

      for (int it = 0; it < 40; it++) begin
         int nc, nd;
         nc = $urandom_range(0, 3);
         nd = $urandom_range(0, 3);
         if (nc + nd == 0) nc = 1;
         for (int i = 0; i < nc; i++) stim_q[0].push_back(rand_req());
         for (int i = 0; i < nd; i++) stim_q[1].push_back(rand_req());
         apply_stimulus();
      end

      repeat (3) @(posedge clk);
      check_output("left_writes", 32'(exp_wr.size()), 32'h0);
      check_output("left_order", 32'(order_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
